// File: rtl/traffic_arbiter.sv
// rtl/traffic_arbiter.sv - two-way intersection light sequencer with pedestrian walk
// Six-state ring GA->YA->RA->GB->YB->RB, dwell timer, latched pedestrian requests.
module traffic_arbiter #(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Pa,
  input  logic       Pb,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       Wa,
  output logic       Wb
);

  localparam int T_MAX0 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int T_MAX  = (T_MAX0 > ALLRED_T) ? T_MAX0 : ALLRED_T;
  localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [31:0] GMIN_M1 = 32'(GREEN_MIN - 1);
  localparam logic [31:0] GMAX_M1 = 32'(GREEN_MAX - 1);
  localparam logic [31:0] YEL_M1  = 32'(YELLOW_T - 1);
  localparam logic [31:0] AR_M1   = 32'(ALLRED_T - 1);
  localparam logic [31:0] GMIN    = 32'(GREEN_MIN);

  localparam logic [1:0] L_GREEN  = 2'd0;
  localparam logic [1:0] L_YELLOW = 2'd1;
  localparam logic [1:0] L_RED    = 2'd2;

  typedef enum logic [2:0] {
    S_GA = 3'd0,
    S_YA = 3'd1,
    S_RA = 3'd2,
    S_GB = 3'd3,
    S_YB = 3'd4,
    S_RB = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pa_pend_q, pa_pend_d;
  logic          pb_pend_q, pb_pend_d;
  logic          walk_a_q, walk_a_d;
  logic          walk_b_q, walk_b_d;

  logic [31:0]   tmr_w;
  logic          dem_a, dem_b;
  logic          enter_ga, enter_gb;
  logic          in_green;

  assign tmr_w = 32'(tmr_q);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_GA;
      tmr_q     <= '0;
      pa_pend_q <= 1'b0;
      pb_pend_q <= 1'b0;
      walk_a_q  <= 1'b0;
      walk_b_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pa_pend_q <= pa_pend_d;
      pb_pend_q <= pb_pend_d;
      walk_a_q  <= walk_a_d;
      walk_b_q  <= walk_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dem_a   = Ta | pa_pend_q;
    dem_b   = Tb | pb_pend_q;

    case (state_q)
      S_GA: begin
        if ((tmr_w >= GMIN_M1) && dem_b && (!Ta || (tmr_w >= GMAX_M1))) state_d = S_YA;
      end
      S_YA: begin
        if (tmr_w == YEL_M1) state_d = S_RA;
      end
      S_RA: begin
        if (tmr_w == AR_M1) state_d = S_GB;
      end
      S_GB: begin
        if ((tmr_w >= GMIN_M1) && dem_a && (!Tb || (tmr_w >= GMAX_M1))) state_d = S_YB;
      end
      S_YB: begin
        if (tmr_w == YEL_M1) state_d = S_RB;
      end
      S_RB: begin
        if (tmr_w == AR_M1) state_d = S_GA;
      end
      default: state_d = S_GA;
    endcase

    enter_ga = (state_q == S_RB) && (state_d == S_GA);
    enter_gb = (state_q == S_RA) && (state_d == S_GB);
    in_green = (state_q == S_GA) || (state_q == S_GB);

    // Only greens can dwell long enough to need saturation; Y/R leave at their terminal count.
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (in_green && (tmr_w >= GMAX_M1)) begin
      tmr_d = tmr_q;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    // A request arriving on the entry cycle is served now rather than carried over.
    pa_pend_d = (pa_pend_q | Pa) & ~enter_ga;
    pb_pend_d = (pb_pend_q | Pb) & ~enter_gb;
    walk_a_d  = enter_ga ? (pa_pend_q | Pa) : walk_a_q;
    walk_b_d  = enter_gb ? (pb_pend_q | Pb) : walk_b_q;
  end

  always_comb begin
    La = L_RED;
    Lb = L_RED;
    case (state_q)
      S_GA:    La = L_GREEN;
      S_YA:    La = L_YELLOW;
      S_GB:    Lb = L_GREEN;
      S_YB:    Lb = L_YELLOW;
      default: begin
        La = L_RED;
        Lb = L_RED;
      end
    endcase
    Wa = walk_a_q && (state_q == S_GA) && (tmr_w < GMIN);
    Wb = walk_b_q && (state_q == S_GB) && (tmr_w < GMIN);
  end

endmodule

// File: tb/tb_traffic_arbiter.sv
// tb/tb_traffic_arbiter.sv - directed self-checking bench for traffic_arbiter
module tb_traffic_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ta = 1'b0, tb = 1'b0, pa = 1'b0, pb = 1'b0;
  logic [1:0] la, lb, la_o, lb_o;
  logic       wa, wb, wa_o, wb_o;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  traffic_arbiter u_dut (
    .clk(clk), .Reset(rst), .Ta(ta), .Tb(tb), .Pa(pa), .Pb(pb),
    .La(la), .Lb(lb), .Wa(wa), .Wb(wb)
  );

  traffic_arbiter #(.GREEN_MIN(2), .GREEN_MAX(3), .YELLOW_T(1), .ALLRED_T(2)) u_ov (
    .clk(clk), .Reset(rst), .Ta(ta), .Tb(tb), .Pa(pa), .Pb(pb),
    .La(la_o), .Lb(lb_o), .Wa(wa_o), .Wb(wb_o)
  );

  typedef struct {
    logic       ta, tb, pa, pb;
    logic [1:0] la, lb;
    logic       wa, wb;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic chk(input string nm, input logic [1:0] al, input logic [1:0] bl,
                     input logic aw, input logic bw, input logic [1:0] el,
                     input logic [1:0] eb, input logic ew, input logic ewb);
    checks++;
    if ({al, bl, aw, bw} !== {el, eb, ew, ewb}) begin
      errors++;
      $display("FAIL %s edge %0d: got La=%0d Lb=%0d Wa=%0b Wb=%0b, want La=%0d Lb=%0d Wa=%0b Wb=%0b",
               nm, edge_n, al, bl, aw, bw, el, eb, ew, ewb);
    end
  endtask

  task automatic chk_m(input string nm, input logic [1:0] el, input logic [1:0] eb,
                       input logic ew, input logic ewb);
    chk(nm, la, lb, wa, wb, el, eb, ew, ewb);
  endtask

  task automatic chk_o(input string nm, input logic [1:0] el, input logic [1:0] eb,
                       input logic ew, input logic ewb);
    chk(nm, la_o, lb_o, wa_o, wb_o, el, eb, ew, ewb);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ta = 1'b0; tb = 1'b0; pa = 1'b0; pb = 1'b0;
    @(negedge clk);
    chk_m("reset_main", 2'd0, 2'd2, 1'b0, 1'b0);
    chk_o("reset_ovr", 2'd0, 2'd2, 1'b0, 1'b0);
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].ta = 1'b0; tbl[i].tb = 1'b1; tbl[i].pa = 1'b0; tbl[i].pb = 1'b0;
      tbl[i].wa = 1'b0; tbl[i].wb = 1'b0;
      if (i < 4)      begin tbl[i].la = 2'd0; tbl[i].lb = 2'd2; end
      else if (i < 6) begin tbl[i].la = 2'd1; tbl[i].lb = 2'd2; end
      else if (i < 7) begin tbl[i].la = 2'd2; tbl[i].lb = 2'd2; end
      else            begin tbl[i].la = 2'd2; tbl[i].lb = 2'd0; end
    end

    #1 rst = 1'b1;
    #2;

    // Ta=0, Tb=1: handover GA->YA->RA->GB
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ta = tbl[i].ta; tb = tbl[i].tb; pa = tbl[i].pa; pb = tbl[i].pb;
      tick();
      chk_m("tbl_handover", tbl[i].la, tbl[i].lb, tbl[i].wa, tbl[i].wb);
    end

    // Asynchronous reset in the middle of yellow
    do_reset();
    ta = 1'b0; tb = 1'b1;
    run_to(6); chk_m("pre_async_ya", 2'd1, 2'd2, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 chk_m("async_reset", 2'd0, 2'd2, 1'b0, 1'b0);

    // Both sensors held: max-green alternation
    do_reset();
    ta = 1'b1; tb = 1'b1;
    run_to(9);  chk_m("both_ga_9", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(10); chk_m("both_ya_10", 2'd1, 2'd2, 1'b0, 1'b0);
    run_to(12); chk_m("both_ra_12", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(13); chk_m("both_gb_13", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(22); chk_m("both_gb_22", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(23); chk_m("both_yb_23", 2'd2, 2'd1, 1'b0, 1'b0);
    run_to(25); chk_m("both_rb_25", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(26); chk_m("both_ga_26", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(36); chk_m("both_ya_36", 2'd1, 2'd2, 1'b0, 1'b0);
    begin
      int bad = 0;
      while (edge_n < 100) begin
        tick();
        if (la == 2'd3 || lb == 2'd3 || (la != 2'd2 && lb != 2'd2)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL never_3_or_conflict: got %0d bad cycles, want 0", bad);
      end
    end

    // Pb pulse at edge 3 with no vehicles
    do_reset();
    run_to(2);
    pb = 1'b1; tick(); pb = 1'b0;
    run_to(4);  chk_m("pb_ga_4", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(5);  chk_m("pb_ya_5", 2'd1, 2'd2, 1'b0, 1'b0);
    run_to(7);  chk_m("pb_ra_7", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(8);  chk_m("pb_gb_walk_8", 2'd2, 2'd0, 1'b0, 1'b1);
    run_to(12); chk_m("pb_gb_walk_12", 2'd2, 2'd0, 1'b0, 1'b1);
    run_to(13); chk_m("pb_gb_nowalk_13", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(30); chk_m("pb_gb_hold_30", 2'd2, 2'd0, 1'b0, 1'b0);
    ta = 1'b1;
    run_to(31); chk_m("pb_yb_31", 2'd2, 2'd1, 1'b0, 1'b0);
    run_to(33); chk_m("pb_rb_33", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(34); chk_m("pb_ga_34", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(46); chk_m("pb_pend_cleared_46", 2'd0, 2'd2, 1'b0, 1'b0);

    // No demand: GA holds with saturated timer, then Tb at edge 50
    do_reset();
    run_to(1);  chk_m("idle_1", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(20); chk_m("idle_20", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(49); chk_m("idle_49", 2'd0, 2'd2, 1'b0, 1'b0);
    tb = 1'b1;
    tick();     chk_m("idle_tb_ya_50", 2'd1, 2'd2, 1'b0, 1'b0);

    // Pa coincident with RB->GA entry edge
    do_reset();
    tb = 1'b1;
    run_to(8);  chk_m("pa_gb_8", 2'd2, 2'd0, 1'b0, 1'b0);
    ta = 1'b1; tb = 1'b0;
    run_to(13); chk_m("pa_yb_13", 2'd2, 2'd1, 1'b0, 1'b0);
    run_to(15); chk_m("pa_rb_15", 2'd2, 2'd2, 1'b0, 1'b0);
    pa = 1'b1; tick(); pa = 1'b0;
    chk_m("pa_entry_walk_16", 2'd0, 2'd2, 1'b1, 1'b0);
    run_to(20); chk_m("pa_walk_20", 2'd0, 2'd2, 1'b1, 1'b0);
    run_to(21); chk_m("pa_nowalk_21", 2'd0, 2'd2, 1'b0, 1'b0);
    tb = 1'b1;
    run_to(26); chk_m("pa_ya_26", 2'd1, 2'd2, 1'b0, 1'b0);
    run_to(29); chk_m("pa_gb_29", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(38); chk_m("pa_gb_38", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(39); chk_m("pa_yb_39", 2'd2, 2'd1, 1'b0, 1'b0);
    run_to(42); chk_m("pa_pend_cleared_42", 2'd0, 2'd2, 1'b0, 1'b0);

    // Overridden timing instance, both sensors held
    do_reset();
    ta = 1'b1; tb = 1'b1;
    run_to(2);  chk_o("ovr_ga_2", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(3);  chk_o("ovr_ya_3", 2'd1, 2'd2, 1'b0, 1'b0);
    run_to(4);  chk_o("ovr_ra_4", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(5);  chk_o("ovr_ra_5", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(6);  chk_o("ovr_gb_6", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(8);  chk_o("ovr_gb_8", 2'd2, 2'd0, 1'b0, 1'b0);
    run_to(9);  chk_o("ovr_yb_9", 2'd2, 2'd1, 1'b0, 1'b0);
    run_to(11); chk_o("ovr_rb_11", 2'd2, 2'd2, 1'b0, 1'b0);
    run_to(12); chk_o("ovr_ga_12", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(14); chk_o("ovr_ga_14", 2'd0, 2'd2, 1'b0, 1'b0);
    run_to(15); chk_o("ovr_ya_15", 2'd1, 2'd2, 1'b0, 1'b0);
    run_to(18); chk_o("ovr_gb_18", 2'd2, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
